// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master (START, addr+R/W, one data byte, ACK, STOP)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             command strobe, accepted only while busy=0
//   rw                0 = write wdata to slave, 1 = read one byte
//   addr[6:0]         target slave address
//   wdata[7:0]        byte to write
//   busy              high from command accept to end of STOP
//   done              one-cycle pulse after the last STOP quarter
//   ack_err           NACK seen on address or write-data ACK; held until next accept
//   rdata[7:0]        byte read, valid with done, held
//   scl, sda_out      bus drives (1 = released/high)
//   sda_in            SDA bus level
//   scl_in            SCL bus level, used only for clock stretching
//
// Parameter CLK_DIV: clk cycles per SCL quarter-period (2..65535).
// Define I2C_MASTER_STRETCH_EN to let a slave stretch SCL during the high phase
// of any bit or STOP; otherwise scl_in is ignored.
module i2c_master_ctrl #(
   parameter int unsigned CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rdata,
   output logic       scl,
   output logic       sda_out,
   input  logic       sda_in,
   input  logic       scl_in
);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MNACK, STOP
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] qcnt;
   logic [1:0]  q;
   logic [2:0]  bit_cnt;
   logic [7:0]  addr_rw;
   logic [7:0]  wdata_r;
   logic [7:0]  rx;
   logic        accept, tick, stall, qe, sample, last;

   assign accept = state == IDLE && start;
   assign tick   = qcnt == 16'(CLK_DIV - 1);

`ifdef I2C_MASTER_STRETCH_EN
   // Q2 is the SCL-high phase of every bit and of STOP; a low bus level there means
   // a slave is holding SCL, so the quarter counter is parked at 0 until it lets go.
   assign stall = state != IDLE && state != START && q == 2'd2 && scl && !scl_in;
`else
   logic unused;
   assign unused = scl_in;
   assign stall  = 1'b0;
`endif

   assign qe     = tick && !stall;
   assign sample = qe && q == 2'd2;
   assign last   = qe && q == 2'd3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = start ? START : IDLE;
         START:     state_nxt = last ? ADDR : START;
         ADDR:      state_nxt = last && bit_cnt == 3'd7 ? ADDR_ACK : ADDR;
         ADDR_ACK:  state_nxt = !last ? ADDR_ACK : ack_err ? STOP : addr_rw[0] ? READ : WRITE;
         WRITE:     state_nxt = last && bit_cnt == 3'd7 ? WRITE_ACK : WRITE;
         WRITE_ACK: state_nxt = last ? STOP : WRITE_ACK;
         READ:      state_nxt = last && bit_cnt == 3'd7 ? MNACK : READ;
         MNACK:     state_nxt = last ? STOP : MNACK;
         STOP:      state_nxt = last ? IDLE : STOP;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = state != IDLE;
      scl     = 1'b1;
      sda_out = 1'b1;
      case (state)
         START: sda_out = ~q[1];
         ADDR: begin
            scl     = q[1];
            sda_out = addr_rw[3'd7 - bit_cnt];
         end
         WRITE: begin
            scl     = q[1];
            sda_out = wdata_r[3'd7 - bit_cnt];
         end
         ADDR_ACK, WRITE_ACK, READ, MNACK: scl = q[1];
         STOP: begin
            scl     = q != 2'd0;
            sda_out = q == 2'd3;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qcnt    <= '0;
         q       <= '0;
         bit_cnt <= '0;
         addr_rw <= '0;
         wdata_r <= '0;
         rx      <= '0;
         rdata   <= '0;
         ack_err <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= state == STOP && last;
         if (accept) begin
            addr_rw <= {addr, rw};
            wdata_r <= wdata;
            ack_err <= 1'b0;
            qcnt    <= '0;
            q       <= '0;
            bit_cnt <= '0;
         end else if (state != IDLE) begin
            qcnt <= stall || tick ? 16'd0 : qcnt + 16'd1;
            if (qe) q <= q + 2'd1;
            if (last) bit_cnt <= state inside {ADDR, WRITE, READ} ? bit_cnt + 3'd1 : 3'd0;
            if (sample && (state == ADDR_ACK || state == WRITE_ACK) && sda_in) ack_err <= 1'b1;
            if (sample && state == READ) rx <= {rx[6:0], sda_in};
            // rx already holds bit 0 here: it was sampled at the Q2->Q3 edge of this bit.
            if (last && state == READ && bit_cnt == 3'd7) rdata <= rx;
         end
      end
   end

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Single-byte I2C bus master that generates SCL and SDA towards `i2c_slave`. It accepts one command through a start/done handshake and sequences the bus: START, 7-bit address plus R/W, and one data byte written or read. It then samples the ACK and issues STOP. It sits directly upstream of `i2c_slave` on the same `clk` domain, and is the stimulus source for that block in system-level sims.

## Interface
- `CLK_DIV`, default 250: `clk` cycles per SCL quarter-period. Legal range 2..65535.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; **asynchronous, active-low; clock `clk`**
- `start`  in  1  command strobe; sampled only when `busy`=0
- `rw`  in  1  0 = write byte to slave, 1 = read byte from slave
- `addr`  in  7  target slave address
- `wdata`  in  8  byte to write
- `busy`  out  1  high from command accept to end of STOP
- `done`  out  1  one-cycle pulse at end of transaction
- `ack_err`  out  1  NACK seen on address or write-data ACK; valid with `done`, held until next accept
- `rdata`  out  8  byte read; valid with `done` when `rw`=1, held
- `scl`  out  1  SCL drive (1 = released/high)
- `sda_out`  out  1  SDA drive (1 = released/high)
- `sda_in`  in  1  SDA bus level
- `scl_in`  in  1  SCL bus level; used only with `I2C_MASTER_STRETCH_EN`

## Operation
- Reset values: `scl`=1, `sda_out`=1, `busy`=0, `done`=0, `ack_err`=0, `rdata`=0, state IDLE.
- Command accept: on a `clk` edge with `start`=1 and `busy`=0, the block does all of the following:
  - latches `addr`, `rw`, `wdata`;
  - clears `ack_err`;
  - goes to START.
- `start` while `busy`=1 is ignored; there is no queueing.
- The quarter tick is a 16-bit counter that wraps at `CLK_DIV`-1. It is reset to 0 on command accept.
- Every state runs for 4 quarters, Q0..Q3.
- FSM sequence:
  - IDLE → START → ADDR(8 bits) → ADDR_ACK
  - If ACK: rw=0 → WRITE(8) → WRITE_ACK → STOP
  - If ACK: rw=1 → READ(8) → MASTER_NACK → STOP
  - If NACK on ADDR_ACK: set `ack_err`, then STOP
  - STOP → IDLE
- START: SDA is 1 in Q0–Q1 and 0 in Q2–Q3. SCL stays 1 throughout.
- Data/ACK bit:
  - SCL is 0 in Q0–Q1 and 1 in Q2–Q3.
  - `sda_out` updates only at the Q0 start.
  - `sda_in` is sampled at the Q2→Q3 boundary.
- ADDR shifts `{addr, rw}`, MSB first. WRITE shifts `wdata`, MSB first.
- ADDR_ACK and WRITE_ACK release SDA (`sda_out`=1). A sampled 1 is a NACK and sets `ack_err`.
- READ releases SDA and shifts the sampled bits into `rdata`, MSB first. MASTER_NACK drives `sda_out`=1 (single-byte read).
- STOP:
  - Q0: SCL=0, SDA=0.
  - Q1–Q2: SCL=1, SDA=0.
  - Q3: SCL=1, SDA=1.
- The 3-bit bit counter counts 0..7 and wraps to the ACK state on 7.
- Reset mid-transaction releases `scl` and `sda_out` immediately (async) and abandons the command. No `done` is issued.

## Timing
- `busy` rises on the `clk` edge after accept.
- Bus activity starts in the same cycle as the `busy` rise.
- A full transaction is 80 quarters: START 4, address+ACK 36, data+ACK 36, STOP 4. This is 80·`CLK_DIV` clk cycles when not stretched.
- `done`=1 for exactly one cycle, in the cycle after the last STOP quarter. `busy` falls in that same cycle.
- A new `start` is accepted in the cycle `done` is high.
- NACK-abort transaction: 44 quarters (START, address+ACK, STOP).

## Configuration
- `I2C_MASTER_STRETCH_EN` defined:
  - In Q2 of any bit or STOP, the quarter counter holds at 0 while `scl`=1 and `scl_in`=0, i.e. a slave is stretching.
  - The counter resumes on the first cycle with `scl_in`=1.
  - Stretching is unbounded.
- Not defined: `scl_in` is ignored and timing is purely counter-driven.

## Test plan
- CLK_DIV=4, write addr=0x51, wdata=0xC5, with the slave ACKing:
  - SCL/SDA show START, then 0xA2, ACK, 0xC5, ACK, STOP;
  - `done` at cycle 321 after accept;
  - `ack_err`=0.
- Read addr=0x51 against `i2c_slave` returning 0xCA → `rdata`=0xCA with `done`, master NACK on bit 9, then STOP.
- Address 0x10, with the slave not ACKing (SDA released) → `ack_err`=1, STOP at quarter 40, `done` at 44·CLK_DIV+1.
- `start` pulsed during busy with a different addr → ignored; the first transaction's bytes are unchanged; exactly one `done`.
- Assert `rst_n`=0 in the middle of the WRITE data bits → `scl`=`sda_out`=1 asynchronously, `busy`=0, no `done`; the next command completes normally.
- With `I2C_MASTER_STRETCH_EN`, hold `scl_in`=0 for 50 cycles on data bit 3 → the transaction lengthens by exactly 50 cycles and the data is intact.
